// File: rtl/mips64_pkg.sv
// Shared definitions for the MIPS64 external memory port: bus widths,
// the arbiter FSM state type and the 8-byte address alignment helper.
package mips64_pkg;

    localparam int MADDR_L = 32;
    localparam int DATA_L  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Memory is addressed in whole 64-bit words, so the low three byte bits are dropped.
    function automatic logic [MADDR_L-1:0] align8(input logic [MADDR_L-1:0] addr);
        return {addr[MADDR_L-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// BUSY-cycle watchdog for the memory port arbiter. Counts enabled cycles
// from a clear and flags the cycle in which the limit is reached.
module mem_arb_timer
    import mips64_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // Count cycles spent waiting; clear holds the counter at zero between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // The LIMIT-th waiting cycle is the one in which the transaction gets aborted.
    always_comb begin
        expired = enable && (count == LAST);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single external memory port between instruction
// fetch (read-only) and memory access (read/write). MA has fixed priority,
// bounded by a streak counter so IF cannot starve. Optional BUSY timeout
// is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mips64_pkg::*;
#(
    parameter int STREAK_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_req,
    input  logic [MADDR_L-1:0] if_addr,
    output logic               if_done,
    output logic [31:0]        if_rdata,
    input  logic               ma_req,
    input  logic               ma_we,
    input  logic [MADDR_L-1:0] ma_addr,
    input  logic [DATA_L-1:0]  ma_wdata,
    output logic               ma_done,
    output logic [DATA_L-1:0]  ma_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MADDR_L-1:0] mem_addr,
    output logic [DATA_L-1:0]  mem_wdata,
    input  logic [DATA_L-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               err
);

    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

    arb_state_t    state;
    logic [SW-1:0] streak;
    logic          owner_if;
    logic          if_hi;
    logic          grant_if;
    logic          tmo_expired;

    // IF wins when it is alone, or when MA has used up its allowed streak.
    always_comb begin
        grant_if = if_req && (!ma_req || streak == STREAK_LIM);
    end

`ifdef ARB_TIMEOUT_EN
    mem_arb_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == IDLE),
        .enable (state == BUSY),
        .expired(tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
    assign err         = 1'b0;
`endif

    // Arbitration FSM with all memory-side and requester-side outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            streak    <= '0;
            owner_if  <= 1'b0;
            if_hi     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            ma_done   <= 1'b0;
            if_rdata  <= '0;
            ma_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || ma_req) begin
                        mem_req <= 1'b1;
                        state   <= BUSY;
                        if (grant_if) begin
                            owner_if <= 1'b1;
                            if_hi    <= if_addr[2];
                            mem_we   <= 1'b0;
                            mem_addr <= align8(if_addr);
                            streak   <= '0;
                        end else begin
                            owner_if  <= 1'b0;
                            mem_we    <= ma_we;
                            mem_addr  <= align8(ma_addr);
                            mem_wdata <= ma_wdata;
                            streak    <= if_req ? streak + 1'b1 : '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (owner_if) begin
                            if_rdata <= if_hi ? mem_rdata[63:32] : mem_rdata[31:0];
                            if_done  <= 1'b1;
                        end else begin
                            if (!mem_we) begin
                                ma_rdata <= mem_rdata;
                            end
                            ma_done <= 1'b1;
                        end
                    end else if (tmo_expired) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
`ifdef ARB_TIMEOUT_EN
                        err     <= 1'b1;
`endif
                        if (owner_if) begin
                            if_done <= 1'b1;
                        end else begin
                            ma_done <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if_done <= 1'b0;
                    ma_done <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    err     <= 1'b0;
`endif
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, starvation
// and reset sequences, timeout behaviour, and a randomized run against a
// transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int STREAK_MAX = 4;
    localparam int TMO        = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ma_req, ma_we, mem_ack;
    logic [31:0] if_addr, ma_addr;
    logic [63:0] ma_wdata, mem_rdata;
    logic        if_done, ma_done, mem_req, mem_we, err;
    logic [31:0] if_rdata, mem_addr;
    logic [63:0] ma_rdata, mem_wdata;

    int total = 0;
    int bad   = 0;

    // Reference model state: streak of MA wins and expected read-data registers.
    int          m_streak = 0;
    logic [31:0] exp_ifr  = '0;
    logic [63:0] exp_mar  = '0;

    typedef struct {
        logic        ir, im, we;
        logic [31:0] ia, ma;
        logic [63:0] wd, rd;
        int          lat;
        logic        junk;
        logic        e_if;
        logic [31:0] e_addr;
        logic [31:0] e_ifr;
        logic [63:0] e_mar;
    } vec_t;

    vec_t vecs[5];

    mem_port_arbiter #(
        .STREAK_MAX (STREAK_MAX),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .ma_req   (ma_req),
        .ma_we    (ma_we),
        .ma_addr  (ma_addr),
        .ma_wdata (ma_wdata),
        .ma_done  (ma_done),
        .ma_rdata (ma_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction; called on a negedge while the FSM is idle, returns on the next idle negedge.
    task automatic run_txn(input logic ir, input logic im, input logic we,
                           input logic [31:0] ia, input logic [31:0] ma,
                           input logic [63:0] wd, input logic [63:0] rd,
                           input int lat, input logic junk, input logic e_if,
                           input logic [31:0] e_addr, input logic [31:0] e_ifr,
                           input logic [63:0] e_mar);
        if_req = ir; ma_req = im; if_addr = ia; ma_addr = ma; ma_we = we; ma_wdata = wd;
        tick();
        chk("mem_req_start", {63'd0, mem_req}, 64'd1);
        chk("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
        chk("mem_we", {63'd0, mem_we}, {63'd0, (!e_if && we)});
        if (!e_if && we) chk("mem_wdata", mem_wdata, wd);
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("mem_req_hold", {63'd0, mem_req}, 64'd1);
            chk("done_early", {62'd0, if_done, ma_done}, 64'd0);
        end
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = junk; mem_rdata = ~rd;
        chk("if_done_pulse", {63'd0, if_done}, {63'd0, e_if});
        chk("ma_done_pulse", {63'd0, ma_done}, {63'd0, !e_if});
        chk("mem_req_resp", {63'd0, mem_req}, 64'd0);
        chk("err_normal", {63'd0, err}, 64'd0);
        if (e_if) if_req = 1'b0; else ma_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        chk("done_cleared", {62'd0, if_done, ma_done}, 64'd0);
        chk("mem_req_idle", {63'd0, mem_req}, 64'd0);
        chk("if_rdata", {32'd0, if_rdata}, {32'd0, e_ifr});
        chk("ma_rdata", ma_rdata, e_mar);
    endtask

    // Predicts the winner and data effects from the arbitration rules, then runs the transaction.
    task automatic model_txn(input logic ir, input logic im, input logic we,
                             input logic [31:0] ia, input logic [31:0] ma,
                             input logic [63:0] wd, output logic won_if);
        logic [63:0] rd;
        logic [31:0] addr;
        rd = {$urandom, $urandom};
        won_if = ir && (!im || m_streak == STREAK_MAX);
        if (won_if) m_streak = 0;
        else if (ir) m_streak = m_streak + 1;
        else m_streak = 0;
        if (won_if) begin
            addr = ia & 32'hFFFF_FFF8;
            exp_ifr = ia[2] ? rd[63:32] : rd[31:0];
        end else begin
            addr = ma & 32'hFFFF_FFF8;
            if (!we) exp_mar = rd;
        end
        run_txn(ir, im, we, ia, ma, wd, rd, int'($urandom_range(1, 4)), 1'($urandom % 2),
                won_if, addr, exp_ifr, exp_mar);
    endtask

    initial begin
        logic        won, ip, mp, rwe;
        logic [31:0] ria, rma;
        logic [63:0] rwd;
        int          busy;

        rst_n = 1'b0; if_req = 0; ma_req = 0; ma_we = 0; mem_ack = 0;
        if_addr = '0; ma_addr = '0; ma_wdata = '0; mem_rdata = '0;
        #12;
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_dones_err", {61'd0, if_done, ma_done, err}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_rdata", {32'd0, if_rdata} | ma_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        vecs[0] = '{1, 0, 0, 32'h104, 32'h0,  64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 2, 0,
                    1, 32'h100, 32'hAAAABBBB, 64'h0};
        vecs[1] = '{0, 1, 1, 32'h0,   32'h20, 64'h1234, 64'hDEAD, 1, 0,
                    0, 32'h20, 32'hAAAABBBB, 64'h0};
        vecs[2] = '{0, 1, 0, 32'h0,   32'h3F, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 1,
                    0, 32'h38, 32'hAAAABBBB, 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{1, 0, 0, 32'h200, 32'h0,  64'h0, 64'h1111_2222_3333_4444, 1, 1,
                    1, 32'h200, 32'h33334444, 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{0, 1, 1, 32'h0,   32'h47, 64'hFFFF_0000_FFFF_0000, 64'h5555, 2, 0,
                    0, 32'h40, 32'h33334444, 64'h0123_4567_89AB_CDEF};
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].ir, vecs[i].im, vecs[i].we, vecs[i].ia, vecs[i].ma,
                    vecs[i].wd, vecs[i].rd, vecs[i].lat, vecs[i].junk, vecs[i].e_if,
                    vecs[i].e_addr, vecs[i].e_ifr, vecs[i].e_mar);
        end
        exp_ifr = 32'h33334444; exp_mar = 64'h0123_4567_89AB_CDEF; m_streak = 0;

        $display("[TB] starvation sequence");
        for (int k = 0; k < 6; k++) begin
            run_txn(1, 1, 0, 32'h500, 32'h600 + 32'(k * 8), 64'h0, 64'h100 + 64'(k), 1, 0,
                    (k == 4), (k == 4) ? 32'h500 : 32'h600 + 32'(k * 8),
                    (k >= 4) ? 32'h104 : 32'h33334444,
                    (k == 5) ? 64'h105 : ((k == 4) ? 64'h103 : 64'h100 + 64'(k)));
        end
        ma_req = 0; if_req = 0;
        exp_ifr = 32'h104; exp_mar = 64'h105; m_streak = 1;
        tick();

        $display("[TB] timeout behaviour");
        ma_req = 1; ma_we = 1; ma_addr = 32'h700; ma_wdata = 64'h77;
        tick();
        busy = 0;
        for (int i = 0; i < 30; i++) begin
            if (!mem_req) break;
            busy++;
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        chk("tmo_busy_cycles", 64'(busy), 64'(TMO));
        chk("tmo_ma_done", {63'd0, ma_done}, 64'd1);
        chk("tmo_err", {63'd0, err}, 64'd1);
        ma_req = 0;
        tick();
        chk("tmo_err_clear", {62'd0, err, ma_done}, 64'd0);
`else
        chk("no_tmo_busy_cycles", 64'(busy), 64'd30);
        mem_ack = 1; mem_rdata = 64'hBAD;
        tick();
        mem_ack = 0;
        chk("no_tmo_ma_done", {63'd0, ma_done}, 64'd1);
        chk("no_tmo_err", {63'd0, err}, 64'd0);
        ma_req = 0;
        tick();
`endif
        chk("tmo_ma_rdata", ma_rdata, exp_mar);
        m_streak = 0;

        $display("[TB] reset during BUSY and ignored acks");
        ma_req = 1; ma_we = 0; ma_addr = 32'h80;
        tick();
        chk("rstbusy_mem_req", {63'd0, mem_req}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("rstbusy_async_drop", {63'd0, mem_req}, 64'd0);
        ma_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1; mem_rdata = 64'hFACE_0000 + 64'(i);
            tick();
            chk("rstbusy_no_done", {61'd0, if_done, ma_done, mem_req}, 64'd0);
            chk("ignored_ack_rdata", {32'd0, if_rdata} | ma_rdata, 64'd0);
        end
        mem_ack = 0;
        exp_ifr = '0; exp_mar = '0; m_streak = 0;

        $display("[TB] randomized run");
        ip = 0; mp = 0; ria = '0; rma = '0; rwd = '0; rwe = 0;
        for (int n = 0; n < 40; n++) begin
            if (!ip && ($urandom % 2 == 1)) begin ip = 1; ria = $urandom; end
            if (!mp && ($urandom % 3 != 0)) begin
                mp = 1; rma = $urandom; rwe = 1'($urandom % 2); rwd = {$urandom, $urandom};
            end
            if (!ip && !mp) begin mp = 1; rma = $urandom; rwe = 0; end
            model_txn(ip, mp, rwe, ria, rma, rwd, won);
            if (won) ip = 0; else mp = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
